// File: rtl/odyssey_video_pkg.sv
// Shared video constants: default panel geometry, framebuffer address
// width and the RGB565 colours used by the pixel path.
package odyssey_video_pkg;

  localparam int DEF_X_SIZE = 240;
  localparam int DEF_Y_SIZE = 240;
  localparam int FB_ADDR_W  = 14;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  // Words in one framebuffer bank after pixel replication is undone.
  function automatic int fb_words(input int xs, input int ys, input int sl2);
    return (xs >> sl2) * (ys >> sl2);
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM holding both framebuffer banks back to back.
// One write port, one registered read port; no reset so it maps onto
// block RAM and keeps its contents across a controller reset.
module fb_dpram #(
  parameter int DW    = 16,
  parameter int AW    = 15,
  parameter int DEPTH = 28800
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Write port plus registered read (second display pipeline stage).
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fb_pixel_fetch.sv
// Double-buffered framebuffer fetch for the LCD video stage.
// Beam position -> stage 1 (address, flags) -> stage 2 (RAM data) -> colour.
// Bank swaps are armed by swap_req and applied on the vsync_i rising edge.
// Optional build macro: FB_TEST_BORDER_EN paints the visible border blue.
module fb_pixel_fetch
  import odyssey_video_pkg::*;
#(
  parameter int X_SIZE     = DEF_X_SIZE,
  parameter int Y_SIZE     = DEF_Y_SIZE,
  parameter int SCALE_LOG2 = 1,
  parameter int COLOR_BITS = 16
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [12:0]           beam_x,
  input  logic [8:0]            beam_y,
  input  logic                  blank_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [13:0]           wr_addr,
  input  logic [COLOR_BITS-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  front_sel,
  output logic                  blank_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic [COLOR_BITS-1:0] color
);

  localparam int FB_W     = X_SIZE >> SCALE_LOG2;
  localparam int FB_WORDS = fb_words(X_SIZE, Y_SIZE, SCALE_LOG2);
  localparam int RAM_AW   = FB_ADDR_W + 1;

  logic [12:0]           pix_x;
  logic [8:0]            pix_y;
  logic [FB_ADDR_W-1:0]  lin_addr;
  logic                  in_range;
  logic [RAM_AW-1:0]     rd_addr_d, rd_addr_q;
  logic [RAM_AW-1:0]     ram_waddr;
  logic                  ram_we;
  logic [COLOR_BITS-1:0] ram_rdata;

  logic s1_blank_q, s1_hs_q, s1_vs_q, s1_oob_q;
  logic s2_blank_q, s2_hs_q, s2_vs_q, s2_oob_q;
`ifdef FB_TEST_BORDER_EN
  logic on_border;
  logic s1_border_q, s2_border_q;
`endif

  logic front_sel_q, swap_pending_q, vsync_prev_q;
  logic vsync_rise, swap_done;

  // Read address: bank base of the front buffer plus the unscaled pixel
  // index; out-of-range beams park on the bank base since their colour is
  // forced to black anyway.
  always_comb begin
    pix_x     = beam_x >> SCALE_LOG2;
    pix_y     = beam_y >> SCALE_LOG2;
    lin_addr  = FB_ADDR_W'(32'(pix_y) * 32'(FB_W) + 32'(pix_x));
    in_range  = (32'(beam_x) < 32'(X_SIZE)) && (32'(beam_y) < 32'(Y_SIZE));
    rd_addr_d = (front_sel_q ? RAM_AW'(FB_WORDS) : '0) +
                (in_range ? RAM_AW'(lin_addr) : '0);
  end

`ifdef FB_TEST_BORDER_EN
  // Border pixels of the visible area, evaluated alongside the address.
  always_comb begin
    on_border = (beam_x == 13'(X_SIZE - 1)) || (beam_x == '0) ||
                (beam_y == 9'(Y_SIZE - 1))  || (beam_y == '0);
  end
`endif

  // Writes target the back bank; addresses past the bank are dropped
  // rather than wrapped, and nothing is accepted in the swap cycle.
  assign vsync_rise = vsync_i && !vsync_prev_q;
  assign swap_done  = !reset && vsync_rise && (swap_pending_q || swap_req);
  assign wr_ready   = !reset && !swap_done;
  assign ram_we     = wr_valid && wr_ready && (32'(wr_addr) < 32'(FB_WORDS));
  assign ram_waddr  = (front_sel_q ? '0 : RAM_AW'(FB_WORDS)) + RAM_AW'(wr_addr);

  // Stage 1: register the read address and the strobes that travel with it.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rd_addr_q   <= '0;
      s1_blank_q  <= 1'b1;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_oob_q    <= 1'b0;
`ifdef FB_TEST_BORDER_EN
      s1_border_q <= 1'b0;
`endif
    end else begin
      rd_addr_q   <= rd_addr_d;
      s1_blank_q  <= blank_i;
      s1_hs_q     <= hsync_i;
      s1_vs_q     <= vsync_i;
      s1_oob_q    <= !in_range;
`ifdef FB_TEST_BORDER_EN
      s1_border_q <= on_border;
`endif
    end
  end

  // Stage 2: align the flags with the registered RAM read data.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      s2_blank_q  <= 1'b1;
      s2_hs_q     <= 1'b0;
      s2_vs_q     <= 1'b0;
      s2_oob_q    <= 1'b0;
`ifdef FB_TEST_BORDER_EN
      s2_border_q <= 1'b0;
`endif
    end else begin
      s2_blank_q  <= s1_blank_q;
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      s2_oob_q    <= s1_oob_q;
`ifdef FB_TEST_BORDER_EN
      s2_border_q <= s1_border_q;
`endif
    end
  end

  // Swap control: arm on request, flip banks on the vsync rising edge.
  always_ff @(posedge clk_pixel) begin
    vsync_prev_q <= vsync_i;
    if (reset) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else if (swap_done) begin
      front_sel_q    <= !front_sel_q;
      swap_pending_q <= 1'b0;
    end else if (swap_req) begin
      swap_pending_q <= 1'b1;
    end
  end

  // Final colour: blanking and range check win over any pixel content.
  always_comb begin
    color = ram_rdata;
`ifdef FB_TEST_BORDER_EN
    if (s2_border_q) color = COLOR_BITS'(RGB565_BLUE);
`endif
    if (s2_blank_q || s2_oob_q) color = COLOR_BITS'(RGB565_BLACK);
  end

  assign blank_o      = s2_blank_q;
  assign hsync_o      = s2_hs_q;
  assign vsync_o      = s2_vs_q;
  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;

  fb_dpram #(
    .DW    (COLOR_BITS),
    .AW    (RAM_AW),
    .DEPTH (2 * FB_WORDS)
  ) u_ram (
    .clk_i   (clk_pixel),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_fb_pixel_fetch.sv
// Scoreboard bench for fb_pixel_fetch (default 240x240, scale 2, RGB565).
// Stimulus pushes expected values tagged with the cycle they must appear;
// a negedge monitor pops and compares them.
module tb_fb_pixel_fetch;

  localparam int K_COLOR = 0, K_BLANK = 1, K_HS = 2, K_VS = 3,
                 K_FRONT = 4, K_PEND = 5, K_WRRDY = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] beam_x;
  logic [8:0]  beam_y;
  logic        blank_i, hsync_i, vsync_i;
  logic        wr_valid, wr_ready;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        swap_req, swap_pending, front_sel;
  logic        blank_o, hsync_o, vsync_o;
  logic [15:0] color;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  fb_pixel_fetch dut (
    .clk_pixel    (clk),
    .reset        (reset),
    .beam_x       (beam_x),
    .beam_y       (beam_y),
    .blank_i      (blank_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_sel    (front_sel),
    .blank_o      (blank_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .color        (color)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act_of(input int k);
    case (k)
      K_COLOR: return 32'(color);
      K_BLANK: return 32'(blank_o);
      K_HS:    return 32'(hsync_o);
      K_VS:    return 32'(vsync_o);
      K_FRONT: return 32'(front_sel);
      K_PEND:  return 32'(swap_pending);
      default: return 32'(wr_ready);
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation expired at cycle %0d (due %0d)", sb[i].name, cyc, sb[i].cyc);
        end else if (act_of(sb[i].kind) !== sb[i].val) begin
          errors++;
          $display("FAIL %s: cycle %0d got %h expected %h", sb[i].name, cyc, act_of(sb[i].kind), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int off, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + off;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected non-blank in-range colour for a pixel with RAM content ram.
  function automatic logic [15:0] exp_pix(input int x, input int y, input logic [15:0] ram);
`ifdef FB_TEST_BORDER_EN
    if (x == 0 || x == 239 || y == 0 || y == 239) return 16'h001F;
`endif
    if (x < 0 || y < 0) return 16'h0000;
    return ram;
  endfunction

  task automatic pix(input int x, input int y, input logic bl, input logic hs, input logic vs,
                     input logic [15:0] exp_c, input string name);
    beam_x  = 13'(x);
    beam_y  = 9'(y);
    blank_i = bl;
    hsync_i = hs;
    vsync_i = vs;
    expect_at(2, K_COLOR, 32'(exp_c), {name, "_color"});
    expect_at(2, K_BLANK, 32'(bl), {name, "_blank"});
    expect_at(2, K_HS, 32'(hs), {name, "_hsync"});
    expect_at(2, K_VS, 32'(vs), {name, "_vsync"});
    step();
  endtask

  task automatic wr(input int addr, input logic [15:0] data, input string name);
    wr_valid = 1'b1;
    wr_addr  = 14'(addr);
    wr_data  = data;
    expect_at(0, K_WRRDY, 32'd1, {name, "_wr_ready"});
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; beam_x = '0; beam_y = '0; blank_i = 1'b1; hsync_i = 1'b0;
    vsync_i = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    step(); step(); step();

    // Reset state
    expect_at(0, K_COLOR, 32'h0, "rst_color");
    expect_at(0, K_BLANK, 32'd1, "rst_blank");
    expect_at(0, K_HS,    32'd0, "rst_hsync");
    expect_at(0, K_VS,    32'd0, "rst_vsync");
    expect_at(0, K_FRONT, 32'd0, "rst_front");
    expect_at(0, K_PEND,  32'd0, "rst_pending");
    expect_at(0, K_WRRDY, 32'd0, "rst_wr_ready");
    step();
    reset = 1'b0;
    step();

    // Fill back bank (bank 1)
    wr(0,   16'hF800, "w0");
    wr(1,   16'h1234, "w1");
    wr(121, 16'h07E0, "w121");
    wr(242, 16'h5555, "w242");

    // Mid-frame swap request, plus a second request while pending
    swap_req = 1'b1;
    expect_at(1, K_PEND,  32'd1, "swap_arm_pending");
    expect_at(1, K_FRONT, 32'd0, "swap_arm_front");
    step();
    swap_req = 1'b0;
    step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    expect_at(0, K_FRONT, 32'd0, "swap_wait_front");
    expect_at(0, K_PEND,  32'd1, "swap_wait_pending");
    step();

    // vsync rise completes the swap; write in that cycle is refused
    vsync_i = 1'b1; wr_valid = 1'b1; wr_addr = 14'd0; wr_data = 16'hBEEF;
    expect_at(0, K_WRRDY, 32'd0, "swap_cycle_wr_ready");
    expect_at(0, K_FRONT, 32'd0, "swap_cycle_front_pre");
    expect_at(1, K_FRONT, 32'd1, "swap_done_front");
    expect_at(1, K_PEND,  32'd0, "swap_done_pending");
    step();
    wr_valid = 1'b0;
    step(); step();
    expect_at(0, K_FRONT, 32'd1, "single_toggle_front");
    expect_at(0, K_PEND,  32'd0, "single_toggle_pending");
    vsync_i = 1'b0;
    step();

    // Display bank 1
    pix(0,   0,   1'b0, 1'b0, 1'b0, exp_pix(0, 0, 16'hF800), "p00");
    pix(1,   1,   1'b0, 1'b0, 1'b0, exp_pix(1, 1, 16'hF800), "p11");
    pix(2,   0,   1'b0, 1'b1, 1'b0, exp_pix(2, 0, 16'h1234), "p20");
    pix(2,   2,   1'b0, 1'b0, 1'b1, exp_pix(2, 2, 16'h07E0), "p22");
    pix(5,   5,   1'b1, 1'b0, 1'b0, 16'h0000, "p55_blank");
    pix(240, 0,   1'b0, 1'b0, 1'b0, 16'h0000, "px_oob");
    pix(0,   240, 1'b0, 1'b0, 1'b0, 16'h0000, "py_oob");
    blank_i = 1'b1;
    step(); step();

    // Back bank is 0: valid write, then an out-of-range one that must drop
    wr(0,     16'h0AAA, "b0w0");
    wr(14400, 16'hDEAD, "wdrop");
    pix(0, 0, 1'b0, 1'b0, 1'b0, exp_pix(0, 0, 16'hF800), "p00_after_drop");
    blank_i = 1'b1;
    step();

    // swap_req coincident with vsync rise
    swap_req = 1'b1; vsync_i = 1'b1;
    expect_at(0, K_FRONT, 32'd1, "coinc_front_pre");
    expect_at(0, K_WRRDY, 32'd0, "coinc_wr_ready");
    expect_at(1, K_FRONT, 32'd0, "coinc_front");
    expect_at(1, K_PEND,  32'd0, "coinc_pending");
    step();
    swap_req = 1'b0;
    step();
    vsync_i = 1'b0;
    step();
    pix(0, 0, 1'b0, 1'b0, 1'b0, exp_pix(0, 0, 16'h0AAA), "p00_bank0");
    blank_i = 1'b1;

    // Swap back to bank 1 ahead of the reset test
    swap_req = 1'b1;
    step();
    swap_req = 1'b0; vsync_i = 1'b1;
    step();
    vsync_i = 1'b0;
    expect_at(0, K_FRONT, 32'd1, "reswap_front");
    step();

    // Reset mid-line
    pix(0, 0, 1'b0, 1'b0, 1'b0, exp_pix(0, 0, 16'hF800), "p00_prerst");
    step();
    reset = 1'b1;
    expect_at(0, K_WRRDY, 32'd0, "midrst_wr_ready");
    expect_at(1, K_COLOR, 32'h0, "midrst_color");
    expect_at(1, K_BLANK, 32'd1, "midrst_blank");
    expect_at(1, K_FRONT, 32'd0, "midrst_front");
    step();
    step();
    reset = 1'b0;
    pix(0, 0, 1'b0, 1'b0, 1'b0, exp_pix(0, 0, 16'h0AAA), "p00_postrst");

`ifdef FB_TEST_BORDER_EN
    pix(239, 100, 1'b0, 1'b0, 1'b0, 16'h001F, "border_239_100");
`endif

    blank_i = 1'b1;
    step(); step(); step(); step();
    if (sb.size() != 0) begin
      checks += sb.size();
      errors += sb.size();
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
